// File: rtl/dbus_arbiter_pkg.sv
// Shared definitions for the two-master data-bus arbiter: grant state
// encoding and watchdog counter sizing.
package dbus_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_GNT0 = 2'd1,
      ST_GNT1 = 2'd2
   } state_t;

   localparam int WD_W = 8;

endpackage

// File: rtl/bus_watchdog.sv
// Strobe watchdog: counts un-acknowledged strobe cycles and emits a
// registered one-cycle error pulse once the limit is reached.
module bus_watchdog
   import dbus_arbiter_pkg::*;
#(
   parameter int TIMEOUT = 15
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clear,
   input  logic i_active,
   input  logic i_ack,
   output logic o_err
);

   localparam logic [WD_W-1:0] LIMIT = WD_W'(TIMEOUT - 1);

   logic [WD_W-1:0] r_cnt;
   logic            r_err;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge i_clk) begin
      if (i_rst || i_clear || i_ack || !i_active) begin
         r_cnt <= '0;
         r_err <= 1'b0;
      end else if (r_cnt == LIMIT) begin
         r_cnt <= '0;
         r_err <= 1'b1;
      end else begin
         r_cnt <= r_cnt + 1'b1;
         r_err <= 1'b0;
      end
   end

   assign o_err = r_err;

endmodule

// File: rtl/dbus_arbiter.sv
// Round-robin Wishbone arbiter sharing the program-memory data port between
// the CPU data bus (master 0) and a secondary master (master 1).
module dbus_arbiter
   import dbus_arbiter_pkg::*;
#(
   parameter int AW      = 13,
   parameter int TIMEOUT = 15
) (
   input  logic          sys_clk_i,
   input  logic          sys_rst_i,

   input  logic [AW:1]   m0_adr_i,
   input  logic [15:0]   m0_dat_i,
   input  logic          m0_we_i,
   input  logic          m0_cyc_i,
   input  logic          m0_stb_i,
   output logic [15:0]   m0_dat_o,
   output logic          m0_ack_o,
   output logic          m0_err_o,

   input  logic [AW:1]   m1_adr_i,
   input  logic [15:0]   m1_dat_i,
   input  logic          m1_we_i,
   input  logic          m1_cyc_i,
   input  logic          m1_stb_i,
   output logic [15:0]   m1_dat_o,
   output logic          m1_ack_o,
   output logic          m1_err_o,

   output logic [AW:1]   s_adr_o,
   output logic [15:0]   s_dat_o,
   output logic          s_we_o,
   output logic          s_cyc_o,
   output logic          s_stb_o,
   input  logic [15:0]   s_dat_i,
   input  logic          s_ack_i
);

   state_t r_state;
   state_t w_state_next;
   logic   r_last;
   logic   w_wd_err;

   always_ff @(posedge sys_clk_i) begin
      if (sys_rst_i) begin
         r_state <= ST_IDLE;
         r_last  <= 1'b1;
      end else begin
         r_state <= w_state_next;
         if (w_state_next == ST_GNT0) begin
            r_last <= 1'b0;
         end else if (w_state_next == ST_GNT1) begin
            r_last <= 1'b1;
         end
      end
   end

   // Ties go to the master that was not granted last; a grant is only
   // released once its owner drops CYC, always through an IDLE cycle.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (m0_cyc_i && (!m1_cyc_i || r_last)) begin
               w_state_next = ST_GNT0;
            end else if (m1_cyc_i) begin
               w_state_next = ST_GNT1;
            end
         end
         ST_GNT0: if (!m0_cyc_i) w_state_next = ST_IDLE;
         ST_GNT1: if (!m1_cyc_i) w_state_next = ST_IDLE;
         default: w_state_next = ST_IDLE;
      endcase
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      s_adr_o = m0_adr_i;
      s_dat_o = m0_dat_i;
      s_we_o  = m0_we_i;
      s_cyc_o = 1'b0;
      s_stb_o = 1'b0;
      if (r_state == ST_GNT0) begin
         s_cyc_o = m0_cyc_i;
         s_stb_o = m0_stb_i;
      end else if (r_state == ST_GNT1) begin
         s_adr_o = m1_adr_i;
         s_dat_o = m1_dat_i;
         s_we_o  = m1_we_i;
         s_cyc_o = m1_cyc_i;
         s_stb_o = m1_stb_i;
      end
   end

   assign m0_dat_o = s_dat_i;
   assign m1_dat_o = s_dat_i;
   assign m0_ack_o = s_ack_i && (r_state == ST_GNT0) && m0_stb_i;
   assign m1_ack_o = s_ack_i && (r_state == ST_GNT1) && m1_stb_i;

   bus_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .i_clk    (sys_clk_i),
      .i_rst    (sys_rst_i),
      .i_clear  (w_state_next != r_state),
      .i_active (s_stb_o),
      .i_ack    (s_ack_i),
      .o_err    (w_wd_err)
   );

   // r_last names the owner of the timed-out transfer; it cannot change
   // while an error pulse is pending because a new grant starts from IDLE.
   assign m0_err_o = w_wd_err && !r_last;
   assign m1_err_o = w_wd_err &&  r_last;

endmodule

// File: doc/dbus_arbiter.md
# dbus_arbiter

Two-master, one-slave Wishbone arbiter that shares the program-memory data port between the CPU data bus (master 0) and a secondary bus master (master 1, e.g. DMA or serial loader). It sits between the masters and the memory's data port. Its duties are:
- grant the port to one master at a time;
- hold the grant for the whole of that master's cycle (CYC lock);
- resolve simultaneous requests by round-robin;
- terminate hung transfers with an error pulse.

## Interface
Parameters:
- AW, default 13: address MSB; addresses are word addresses [AW:1].
- TIMEOUT, default 15: cycles of STB-without-ACK tolerated before an error is raised. Legal range 2..255.

Ports:
- sys_clk_i  in  1  system clock. The block runs in this single clock domain.
- sys_rst_i  in  1  reset. Synchronous and active-high, sampled on the rising edge of sys_clk_i.
- m0_adr_i / m1_adr_i  in  AW  word address.
- m0_dat_i / m1_dat_i  in  16  write data.
- m0_we_i / m1_we_i  in  1  write enable.
- m0_cyc_i / m1_cyc_i  in  1  bus cycle request / lock.
- m0_stb_i / m1_stb_i  in  1  transfer strobe.
- m0_dat_o / m1_dat_o  out  16  read data; always driven from s_dat_i.
- m0_ack_o / m1_ack_o  out  1  transfer acknowledge.
- m0_err_o / m1_err_o  out  1  timeout error; registered, one-cycle pulse.
- s_adr_o  out  AW  slave address.
- s_dat_o  out  16  slave write data.
- s_we_o  out  1  slave write enable.
- s_cyc_o  out  1  slave bus cycle.
- s_stb_o  out  1  slave strobe.
- s_dat_i  in  16  slave read data.
- s_ack_i  in  1  slave acknowledge.

## Operation
- **States:** IDLE, GNT0, GNT1. Reset state is IDLE. A `last` register (the master most recently granted) resets to 1, so master 0 wins the first tie.
- **From IDLE:**
  - Only m0_cyc_i high: go to GNT0.
  - Only m1_cyc_i high: go to GNT1.
  - Both high: grant the master that is not `last`.
  - Neither high: stay in IDLE.
  - On entering GNTn, set `last` to n.
- **GNTn to IDLE:** leave when mn_cyc_i is sampled low. There is no direct GNT0↔GNT1 transition; every handover passes through at least one IDLE cycle.
- **No preemption:** the grant is never revoked while the granted master holds CYC, including across multiple STB transfers and idle STB-low gaps.
- **Slave-side outputs:**
  - Combinational mux of the granted master's adr/dat/we/cyc/stb onto the s_* outputs.
  - In IDLE: s_cyc_o and s_stb_o are 0; s_adr_o, s_dat_o and s_we_o are driven from m0.
- **ACK routing:** mn_ack_o = s_ack_i & (state==GNTn) & mn_stb_i, combinational. The non-granted master's ack is 0.
- **Watchdog:**
  - An 8-bit counter clears on reset, on s_ack_i, whenever s_stb_o is 0, and on any state change.
  - It increments each cycle that s_stb_o=1 and s_ack_i=0.
  - When the count reaches TIMEOUT-1 with no ack this cycle, the granted master's err_o is registered high for exactly one cycle, and the counter clears.
  - The grant is kept; the master is expected to drop CYC.
- **Reset mid-operation:**
  - The next edge forces IDLE, `last`=1, counter=0, and both err_o=0.
  - s_cyc_o and s_stb_o go low in the same cycle the state becomes IDLE.
  - Any in-flight slave ACK arriving after that is discarded.

## Timing
- **Grant latency:** 1 cycle. A CYC raised before edge n makes s_cyc_o high after edge n.
- **Read with the 2-cycle program memory:** master strobes at cycle 0; s_stb_o goes high at cycle 1; ack is observed at cycle 2. The master sees the ack in the same cycle as s_ack_i.
- **Handover bubble:** the losing requester is granted 2 cycles after the winner drops CYC (one IDLE cycle, then GNT).
- **Error:** err_o rises on the edge after TIMEOUT consecutive un-acked strobe cycles.
- **Output reset values:** all err_o are 0. s_cyc_o, s_stb_o and the ack_o outputs are 0, because the state is IDLE.

## Structure
- Shared package holds:
  - the state encoding constants ST_IDLE=2'd0, ST_GNT0=2'd1, ST_GNT1=2'd2;
  - the watchdog counter width (8).
- One natural sub-module, `bus_watchdog`, containing the counter and error pulse generation. Its ports: clear, active, ack, err. The FSM, round-robin pointer and muxes stay in dbus_arbiter.

## Test plan
- **Single master:** m0 reads adr 0x0010 with a slave ack delay of 1 → s_stb_o high 1 cycle after m0_cyc_i; m0_ack_o coincides with s_ack_i; m0_dat_o equals s_dat_i (0xBEEF); m1_ack_o stays 0.
- **Simultaneous request after reset:** both masters assert CYC in the same cycle → GNT0 first. Once m0 drops CYC: IDLE for 1 cycle, then GNT1. Repeating the simultaneous request then grants m1 first.
- **CYC lock:** m0 holds CYC across 3 writes (0x0100..0x0102) while m1 requests continuously → m1 gets no s_stb_o until 2 cycles after m0_cyc_i falls.
- **Timeout:** slave never acks, TIMEOUT=15 → m0_err_o pulses exactly once, 15 cycles after s_stb_o rose, and the grant is retained. After m0 drops CYC, a pending m1 is granted normally.
- **Reset mid-transfer:** sys_rst_i pulsed while in GNT1 with stb high → state IDLE on the next edge; s_cyc_o=0; the late s_ack_i does not reach m1_ack_o; the next simultaneous request grants m0.
